conv1_buf_ctrl: RTL and testbench

- Sequences the four conv1 output buffers (dual-port BRAMs, 8-bit data, 12-bit address, shared address/enable bus).
- Port A side: accepts one conv1 output frame as a valid/ready stream and writes it linearly.
- Port B side: replays the frame RD_PASSES times to conv2 as a valid/ready stream, with backpressure absorbed by BRAM output hold.
- Sits between the conv1 engine and conv2 input; the buffer datapath stays outside this block.

---
 rtl/conv1_buf_ctrl_pkg.sv | 15 +
 rtl/conv1_buf_ctrl_if.sv | 34 +++
 rtl/conv1_buf_ctrl_rd_seq.sv | 101 ++++++++++
 rtl/conv1_buf_ctrl.sv | 94 +++++++++
 tb/tb_conv1_buf_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv1_buf_ctrl_pkg.sv
// Shared types and buffer geometry for the conv1 output buffer controller.
// Buffer width/depth are fixed by the BRAM macro.
package conv_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BUF_ADDR_W = 12;
  localparam int BUF_DATA_W = 8;

endpackage

// File: rtl/conv1_buf_ctrl_if.sv
// Control-side bundle between the conv1 engine, the buffer port enables and conv2.
// The master modport is the controller; the slave modport is its environment.
interface conv1_buf_ctrl_if;
  import conv_buf_pkg::*;

  logic                  frame_start;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  ena;
  logic                  wea;
  logic [BUF_ADDR_W-1:0] addra;
  logic                  enb;
  logic                  web;
  logic [BUF_ADDR_W-1:0] addrb;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_last;
  logic [3:0]            pass_idx;
  logic                  busy;
  logic                  done;

  modport master (
    input  frame_start, wr_valid, rd_ready,
    output wr_ready, ena, wea, addra, enb, web, addrb,
           rd_valid, rd_last, pass_idx, busy, done
  );

  modport slave (
    output frame_start, wr_valid, rd_ready,
    input  wr_ready, ena, wea, addra, enb, web, addrb,
           rd_valid, rd_last, pass_idx, busy, done
  );

endinterface

// File: rtl/conv1_buf_ctrl_rd_seq.sv
// Port B replay sequencer: walks the frame RD_PASSES times into a latency-1 BRAM.
// enb doubles as the BRAM output clock enable, so a stalled word is held in doutb.
module conv1_buf_rd_seq
  import conv_buf_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 676,
  parameter int unsigned RD_PASSES = 4,
  parameter int unsigned ADDR_W    = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              rd_ready_i,
  output logic              enb_o,
  output logic [ADDR_W-1:0] addrb_o,
  output logic              rd_valid_o,
  output logic              rd_last_o,
  output logic [3:0]        pass_idx_o,
  output logic              final_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [3:0]        LAST_PASS = 4'(RD_PASSES - 1);

  logic              act_q, act_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]        pass_q, pass_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [3:0]        pass_idx_q, pass_idx_d;

  logic advance, issue, wrap, last_pass;

  assign advance   = en_i & (~rd_valid_q | rd_ready_i);
  assign issue     = advance & act_q;
  assign wrap      = (rd_ptr_q == LAST_ADDR);
  assign last_pass = (pass_q == LAST_PASS);

  always_comb begin
    act_d      = act_q;
    rd_ptr_d   = rd_ptr_q;
    pass_d     = pass_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    pass_idx_d = pass_idx_q;

    // Armed on the final write beat so the first read issues the cycle READ begins.
    if (start_i) begin
      act_d    = 1'b1;
      rd_ptr_d = '0;
      pass_d   = '0;
    end

    if (issue) begin
      if (wrap) begin
        rd_ptr_d = '0;
        if (last_pass) begin
          pass_d = '0;
          act_d  = 1'b0;
        end else begin
          pass_d = pass_q + 4'd1;
        end
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (advance) begin
      rd_valid_d = issue;
      rd_last_d  = issue & wrap;
      pass_idx_d = issue ? pass_q : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= 1'b0;
      rd_ptr_q   <= '0;
      pass_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      pass_idx_q <= '0;
    end else begin
      act_q      <= act_d;
      rd_ptr_q   <= rd_ptr_d;
      pass_q     <= pass_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      pass_idx_q <= pass_idx_d;
    end
  end

  assign enb_o      = advance;
  assign addrb_o    = rd_ptr_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign pass_idx_o = pass_idx_q;
  assign final_o    = rd_valid_q & rd_ready_i & rd_last_q & (pass_idx_q == LAST_PASS);

endmodule

// File: rtl/conv1_buf_ctrl.sv
// Sequences one conv1 output frame into the buffer (port A) and replays it RD_PASSES
// times to conv2 (port B); holds the frame FSM and write pointer.
module conv1_buf_ctrl
  import conv_buf_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 676,
  parameter int unsigned RD_PASSES = 4,
  parameter int unsigned ADDR_W    = BUF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  conv1_buf_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic wr_beat, wr_last, rd_en, rd_final;
  logic wr_ready, ena, busy, done;

  assign wr_beat = (state_q == WRITE) & bus.wr_valid;
  assign wr_last = wr_beat & (wr_ptr_q == LAST_ADDR);
  assign rd_en   = (state_q == READ);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_ready = 1'b0;
    ena      = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.frame_start) state_d = WRITE;
      end
      WRITE: begin
        wr_ready = 1'b1;
        ena      = bus.wr_valid;
        if (wr_beat) wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
        if (wr_last) state_d = READ;
      end
      READ: begin
        if (rd_final) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  conv1_buf_rd_seq #(
    .FRAME_LEN (FRAME_LEN),
    .RD_PASSES (RD_PASSES),
    .ADDR_W    (ADDR_W)
  ) u_rd_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (rd_en),
    .start_i    (wr_last),
    .rd_ready_i (bus.rd_ready),
    .enb_o      (bus.enb),
    .addrb_o    (bus.addrb),
    .rd_valid_o (bus.rd_valid),
    .rd_last_o  (bus.rd_last),
    .pass_idx_o (bus.pass_idx),
    .final_o    (rd_final)
  );

  // Address is parked at 0 outside WRITE so the bus reads quiet while idle.
  assign bus.addra    = (state_q == WRITE) ? wr_ptr_q : '0;
  assign bus.wr_ready = wr_ready;
  assign bus.ena      = ena;
  assign bus.wea      = ena;
  assign bus.web      = 1'b0;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_conv1_buf_ctrl.sv
// Bench for conv1_buf_ctrl: BRAM model on both ports, scoreboard of expected read words,
// and a small second instance for the single-word frame.
module tb_conv1_buf_ctrl;
  import conv_buf_pkg::*;

  localparam int FL = 8;
  localparam int RP = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [3:0] pass;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv1_buf_ctrl_if bus();
  conv1_buf_ctrl_if bus1();

  conv1_buf_ctrl #(.FRAME_LEN(FL), .RD_PASSES(RP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  conv1_buf_ctrl #(.FRAME_LEN(1), .RD_PASSES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [BUF_DATA_W-1:0] dina;
  logic [BUF_DATA_W-1:0] doutb;
  logic [BUF_DATA_W-1:0] mem [0:4095];

  always @(posedge clk) begin
    if (bus.ena && bus.wea) mem[bus.addra] <= dina;
    if (bus.enb) doutb <= mem[bus.addrb];
  end

  rd_exp_t sb[$];
  int vec = 0;
  int err = 0;
  int cyc = 0;
  int wr_exp_addr = 0;
  int wr_beats = 0;
  int last_wr_cyc = 0;
  int fin_cyc = -100;
  int done_cnt = 0;
  int rd_acc = 0;
  bit first_rd = 1'b1;
  bit holding = 1'b0;
  logic [7:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs8();
    return 64'({bus.wr_ready, bus.ena, bus.wea, bus.addra, bus.enb, bus.web, bus.addrb,
                bus.rd_valid, bus.rd_last, bus.pass_idx, bus.busy, bus.done});
  endfunction

  function automatic logic [63:0] outs1();
    return 64'({bus1.wr_ready, bus1.ena, bus1.wea, bus1.addra, bus1.enb, bus1.web, bus1.addrb,
                bus1.rd_valid, bus1.rd_last, bus1.pass_idx, bus1.busy, bus1.done});
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard on each accepted read word.
  always @(negedge clk) begin
    rd_exp_t e;
    cyc++;
    if (!rst_n) begin
      wr_exp_addr = 0;
      wr_beats    = 0;
      first_rd    = 1'b1;
      holding     = 1'b0;
      fin_cyc     = -100;
      rd_acc      = 0;
    end else begin
      if (bus.ena) begin
        check("wea_with_ena", 64'(bus.wea), 64'd1);
        check("ena_needs_wr_valid", 64'(bus.wr_valid), 64'd1);
        check("addra_seq", 64'(bus.addra), 64'(wr_exp_addr));
        wr_beats++;
        last_wr_cyc = cyc;
        wr_exp_addr = (wr_exp_addr == FL - 1) ? 0 : wr_exp_addr + 1;
      end
      if (bus.rd_valid && first_rd) begin
        first_rd = 1'b0;
        check("writes_before_read", 64'(wr_beats), 64'(FL));
        check("first_rd_latency", 64'(cyc - last_wr_cyc), 64'd2);
      end
      if (holding && bus.rd_valid) check("stall_hold_data", 64'(doutb), 64'(held));
      holding = bus.rd_valid && !bus.rd_ready;
      held    = doutb;
      if (bus.rd_valid && !bus.rd_ready) check("enb_low_in_stall", 64'(bus.enb), 64'd0);
      if (bus.rd_valid && bus.rd_ready) begin
        rd_acc++;
        if (sb.size() == 0) begin
          vec++;
          err++;
          $display("FAIL sb_underflow: got unexpected word %0h expected none", doutb);
        end else begin
          e = sb.pop_front();
          check("rd_data", 64'(doutb), 64'(e.d));
          check("rd_last", 64'(bus.rd_last), 64'(e.last));
          check("pass_idx", 64'(bus.pass_idx), 64'(e.pass));
          if (e.last && e.pass == 4'(RP - 1)) fin_cyc = cyc;
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_after_final", 64'(cyc - fin_cyc), 64'd1);
        wr_beats = 0;
        first_rd = 1'b1;
        rd_acc   = 0;
      end
    end
  end

  task automatic write_frame(input logic [7:0] base, input bit toggle, input bit poke);
    for (int p = 0; p < RP; p++)
      for (int a = 0; a < FL; a++)
        sb.push_back('{d: 8'(base + 8'(a)), last: (a == FL - 1), pass: 4'(p)});
    @(posedge clk); #1;
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      bus.wr_valid    = 1'b1;
      dina            = 8'(base + 8'(i));
      bus.frame_start = poke && (i == 3);
      @(posedge clk); #1;
      bus.wr_valid    = 1'b0;
      bus.frame_start = 1'b0;
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    for (n = 0; n < 300; n++) begin
      @(posedge clk); #2;
      if (bus.done) break;
    end
    vec++;
    if (n == 300) begin
      err++;
      $display("FAIL %s_timeout: got no done expected done within 300 cycles", tag);
    end
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(posedge clk); #2;
    check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n;
    rst_n            = 1'b0;
    bus.frame_start  = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.rd_ready     = 1'b1;
    bus1.frame_start = 1'b0;
    bus1.wr_valid    = 1'b0;
    bus1.rd_ready    = 1'b1;
    dina             = '0;
    #12;
    check("reset_outputs", outs8(), 64'd0);
    check("reset_outputs_fl1", outs1(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame 1: continuous writes, free-running reads.
    write_frame(8'h10, 1'b0, 1'b0);
    wait_done("f1_cont");

    // Frame 2: wr_valid toggling.
    write_frame(8'h40, 1'b1, 1'b0);
    wait_done("f2_toggle");

    // Frame 3: conv2 stalls three cycles mid-pass.
    write_frame(8'h70, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.rd_ready = 1'b1;
    wait_done("f3_stall");

    // Frame 4: stray frame_start during WRITE and during READ.
    write_frame(8'hA0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    check("busy_after_stray_start", 64'(bus.busy), 64'd1);
    wait_done("f4_stray");

    // Frame 5: asynchronous reset in the second pass.
    write_frame(8'hC0, 1'b0, 1'b0);
    for (n = 0; n < 100; n++) begin
      @(posedge clk); #2;
      if (rd_acc >= FL + 3) break;
    end
    check("reach_pass1_addr3", 64'(n < 100), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs8(), 64'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame 6: clean restart after reset.
    write_frame(8'hE0, 1'b0, 1'b0);
    wait_done("f6_restart");
    check("done_count", 64'(done_cnt), 64'd5);

    // Single-word frame, single pass.
    @(posedge clk); #1;
    bus1.frame_start = 1'b1;
    @(posedge clk); #1;
    bus1.frame_start = 1'b0;
    bus1.wr_valid    = 1'b1;
    #1 check("fl1_one_write", 64'({bus1.ena, bus1.wea, bus1.addra}), 64'({2'b11, 12'd0}));
    @(posedge clk); #1;
    bus1.wr_valid = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(posedge clk); #2;
      if (bus1.rd_valid) break;
    end
    check("fl1_rd_valid_seen", 64'(n < 10), 64'd1);
    check("fl1_last_pass", 64'({bus1.rd_last, bus1.pass_idx}), 64'({1'b1, 4'd0}));
    @(posedge clk); #2;
    check("fl1_done", 64'({bus1.done, bus1.busy, bus1.rd_valid}), 64'({1'b1, 1'b1, 1'b0}));
    @(posedge clk); #2;
    check("fl1_busy_fall", 64'({bus1.done, bus1.busy}), 64'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
